// File: rtl/e_muldiv_pkg.sv
// rtl/e_muldiv_pkg.sv - shared pipeline constants and mul/div op encodings
package e_muldiv_pkg;

   localparam int WORD_W          = 32;
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_t;

endpackage

// File: rtl/e_muldiv_if.sv
// rtl/e_muldiv_if.sv - E-stage mul/div request and HI/LO status bundle
interface e_muldiv_if;
   import e_muldiv_pkg::*;

   logic              e_start;
   logic [2:0]        e_md_op;
   logic [WORD_W-1:0] e_src_a;
   logic [WORD_W-1:0] e_src_b;
   logic              busy;
   logic              md_stall_req;
   logic [WORD_W-1:0] hi_out;
   logic [WORD_W-1:0] lo_out;

   modport master (
      output e_start, e_md_op, e_src_a, e_src_b,
      input  busy, md_stall_req, hi_out, lo_out
   );

   modport slave (
      input  e_start, e_md_op, e_src_a, e_src_b,
      output busy, md_stall_req, hi_out, lo_out
   );

endinterface

// File: rtl/e_muldiv.sv
// rtl/e_muldiv.sv - fixed-latency multiply/divide unit holding HI/LO
module e_muldiv
   import e_muldiv_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   e_muldiv_if.slave  md
);

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   logic [WORD_W-1:0] a, b;
   md_op_t            op;
   logic [63:0]       prod_s, prod_u;
   logic              div_signed, neg_a, neg_b;
   logic [WORD_W-1:0] mag_a, mag_b, den, uq, ur, quot, rem;

   logic [3:0]        count;
   logic              busy_q, suppress;
   logic [WORD_W-1:0] temp_hi, temp_lo, hi_q, lo_q;

   assign a  = md.e_src_a;
   assign b  = md.e_src_b;
   assign op = md_op_t'(md.e_md_op);

   assign prod_u = {32'b0, a} * {32'b0, b};
   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

   // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without
   // relying on signed-overflow behaviour; zero divisor is masked to keep
   // the datapath defined (its result is never committed).
   assign div_signed = (op == MD_DIV);
   assign neg_a      = div_signed & a[31];
   assign neg_b      = div_signed & b[31];
   assign mag_a      = neg_a ? -a : a;
   assign mag_b      = neg_b ? -b : b;
   assign den        = (mag_b == '0) ? 32'd1 : mag_b;
   assign uq         = mag_a / den;
   assign ur         = mag_a % den;
   assign quot       = (neg_a ^ neg_b) ? -uq : uq;
   assign rem        = neg_a ? -ur : ur;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         busy_q   <= 1'b0;
         suppress <= 1'b0;
         temp_hi  <= '0;
         temp_lo  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else if (count == '0) begin
         if (md.e_start) begin
            case (op)
               MD_MULT, MD_MULTU: begin
                  {temp_hi, temp_lo} <= (op == MD_MULT) ? prod_s : prod_u;
                  count    <= MULT_CNT;
                  busy_q   <= 1'b1;
                  suppress <= 1'b0;
               end
               MD_DIV, MD_DIVU: begin
                  temp_hi  <= rem;
                  temp_lo  <= quot;
                  count    <= DIV_CNT;
                  busy_q   <= 1'b1;
                  suppress <= (b == '0);
               end
               MD_MTHI: hi_q <= a;
               MD_MTLO: lo_q <= a;
               default: ;
            endcase
         end
      end else begin
         count <= count - 4'd1;
         if (count == 4'd1) begin
            busy_q <= 1'b0;
            if (!suppress) begin
               hi_q <= temp_hi;
               lo_q <= temp_lo;
            end
         end
      end
   end

   assign md.busy         = busy_q;
   assign md.md_stall_req = md.e_start | busy_q;
   assign md.hi_out       = hi_q;
   assign md.lo_out       = lo_q;

endmodule

// File: doc/e_muldiv.md
# e_muldiv

Multi-cycle integer multiply/divide unit in the E stage of the 5-stage MIPS pipeline. It consumes the final forwarded ALU operands (rs-side and rt-side operand mux outputs) in parallel with the ALU. It runs MULT/MULTU/DIV/DIVU with fixed latency, holds the architectural HI/LO registers, and serves MTHI/MTLO writes. It exports busy status so the hazard unit can stall D-stage HI/LO-dependent instructions.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU
- DIV_CYCLES, 10, busy cycles for DIV/DIVU
- clk  in  1  pipeline clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- e_start  in  1  E-stage instruction is a mul/div/mthi/mtlo; one-cycle pulse per instruction
- e_md_op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6–7 reserved (ignored)
- e_src_a  in  32  forwarded rs operand
- e_src_b  in  32  forwarded rt operand
- busy  out  1  operation in flight (registered)
- md_stall_req  out  1  combinational e_start | busy, for the hazard unit
- hi_out  out  32  HI register
- lo_out  out  32  LO register

## Operation
- Reset (reset=0, asynchronous) forces hi_out=0, lo_out=0, busy=0, counter=0, result temps=0.
- IDLE (counter==0): on an edge with e_start=1:
  - MULT/MULTU: the 64-bit product is captured into temp_hi/temp_lo, and the counter loads MULT_CYCLES.
  - DIV/DIVU: the quotient goes to temp_lo and the remainder to temp_hi. The counter loads DIV_CYCLES.
  - MTHI/MTLO: hi_out or lo_out is written with e_src_a at that edge. The counter is untouched and busy stays 0.
- BUSY (counter!=0): the counter decrements each edge. On the edge where it goes 1→0, temp_hi/temp_lo commit to hi_out/lo_out.
- Arithmetic:
  - MULT: signed 32×32→64; HI = bits 63:32, LO = bits 31:0.
  - MULTU: unsigned.
  - DIV: signed, quotient truncated toward zero, remainder takes the sign of the dividend.
  - DIVU: unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (e_src_b==0, DIV or DIVU): the full DIV_CYCLES busy period still runs. The commit is suppressed, so HI/LO are unchanged.
- e_start while busy=1 is ignored entirely, MTHI/MTLO included. The hazard unit guarantees this does not happen; the block is still defined for it.
- A reserved op with e_start=1 is a no-op.

## Timing
- Latency: e_start sampled at edge T0. busy=1 after T0 through edge T0+N (N = MULT_CYCLES or DIV_CYCLES), i.e. exactly N cycles high. HI/LO update and busy falls at edge T0+N.
- A new operation may start at edge T0+N+... The earliest acceptance is the first edge where busy was 0 beforehand, i.e. edge T0+N+1.
- MTHI/MTLO: single-cycle; the value is visible on hi_out/lo_out the cycle after e_start.
- md_stall_req rises combinationally in the same cycle as e_start, so a D-stage MFHI/MFLO/mul/div stalls immediately.
- Reset mid-operation aborts the op: there is no commit, and busy drops immediately.

## Structure
- Shared pipeline package holds:
  - the MD_OP encodings (MULT..MTLO);
  - default MULT_CYCLES/DIV_CYCLES;
  - the 32-bit word width constant.
- Single module, no sub-modules.
- Counter width is 4 bits, which is sufficient for DIV_CYCLES ≤ 15.
- Temporaries are registered; the product/quotient datapath is combinational ahead of the capture.

## Test plan
- Reset: hold reset=0 for 2 cycles. Expect hi_out=0, lo_out=0, busy=0 and md_stall_req=0 after release.
- MULT 0xFFFFFFFF×2: md_stall_req=1 in the start cycle, then busy=1 for 5 cycles. Expect HI=0xFFFFFFFF, LO=0xFFFFFFFE at edge T0+5, and HI/LO unchanged before that edge.
- MULTU 0xFFFFFFFF×2: expect HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- DIV 0xFFFFFFF9(−7)/2: expect LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles. DIVU 7/2: expect LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF: expect LO=0x80000000, HI=0.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO, each visible the next cycle. Then DIV x/0: expect busy for 10 cycles with HI=0x11, LO=0x22 unchanged. An e_start MULTU 3×3 pulsed during busy is ignored.
- Start DIV 100/7, assert reset=0 at cycle 4 of busy: expect busy=0 and HI=LO=0 immediately, with no later commit. After release, MTLO 0x1234 gives lo_out=0x1234 next cycle.
